// File: rtl/conv_pkg.sv
// conv_pkg: constants, FSM states and helpers for the
// K=3, rate-1/2 (7,5) convolutional code.
package conv_pkg;

  localparam int K = 3;
  localparam int SW = K - 1;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  typedef logic [SW-1:0] cstate_t;

  typedef enum logic [1:0] {
    COLLECT,
    TRACEBACK,
    OUTPUT
  } fsm_t;

  // Encoder output {c0,c1} leaving state s with input bit u.
  function automatic logic [1:0] expected_sym(
    input cstate_t s,
    input logic    u
  );
    logic [K-1:0] r;
    r = {u, s};
    return {^(r & G0), ^(r & G1)};
  endfunction

  // Hamming distance between two 2-bit symbols (0..2).
  function automatic logic [1:0] hamming(
    input logic [1:0] a,
    input logic [1:0] b
  );
    logic [1:0] d;
    d = a ^ b;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// viterbi_acs: one add-compare-select cell.
// Ties go to the predecessor whose s0 is 0.
module viterbi_acs #(
  parameter int W = 7
) (
  input  logic [W-1:0] pm0,
  input  logic [W-1:0] pm1,
  input  logic [1:0]   bm0,
  input  logic [1:0]   bm1,
  output logic [W-1:0] pm_new,
  output logic         dec
);

  logic [W-1:0] sum0;
  logic [W-1:0] sum1;

  // Extend both candidates and keep the strictly smaller one.
  always_comb begin
    sum0   = pm0 + W'(bm0);
    sum1   = pm1 + W'(bm1);
    dec    = (sum1 < sum0);
    pm_new = dec ? sum1 : sum0;
  end

endmodule

// File: rtl/viterbi_decoder.sv
// viterbi_decoder: hard-decision Viterbi decoder for
// the (7,5) code over zero-terminated frames of NUM symbols.
module viterbi_decoder
  import conv_pkg::*;
#(
  parameter int NUM = 16
) (
  input  logic       clk_sig,
  input  logic       reset_sig,
  input  logic       in_valid_sig,
  output logic       in_ready_sig,
  input  logic [1:0] in_sym_sig,
  output logic       out_valid_sig,
  output logic       out_bit_sig,
  output logic       out_last_sig
);

  localparam int PM_W = $clog2(4 * NUM + 1);
  localparam int CW = $clog2(NUM);
  localparam logic [CW-1:0] T_LAST = CW'(NUM - 1);
  localparam logic [CW-1:0] O_LAST = CW'(NUM - 3);
  localparam logic [PM_W-1:0] PM_INIT = PM_W'(2 * NUM);

  fsm_t            state;
  fsm_t            state_nx;
  logic [CW-1:0]   cnt;
  logic [PM_W-1:0] pm [4];
  logic [PM_W-1:0] pm_new [4];
  logic [3:0]      dec;
  logic [3:0]      surv [NUM];
  logic [NUM-1:0]  ubuf;
  cstate_t         tb_st;
  logic            accept;

  assign accept = in_valid_sig & in_ready_sig;

  for (genvar ns = 0; ns < 4; ns++) begin : g_acs
    localparam int U  = ns / 2;
    localparam int S1 = ns % 2;
    localparam int P0 = 2 * S1;
    localparam int P1 = 2 * S1 + 1;

    logic [1:0] bm0;
    logic [1:0] bm1;

    assign bm0 = hamming(in_sym_sig,
                   expected_sym(cstate_t'(P0), 1'(U)));
    assign bm1 = hamming(in_sym_sig,
                   expected_sym(cstate_t'(P1), 1'(U)));

    viterbi_acs #(.W(PM_W)) u_acs (
      .pm0    (pm[P0]),
      .pm1    (pm[P1]),
      .bm0    (bm0),
      .bm1    (bm1),
      .pm_new (pm_new[ns]),
      .dec    (dec[ns])
    );
  end

  // FSM state register.
  always_ff @(posedge clk_sig or posedge reset_sig) begin
    if (reset_sig) state <= COLLECT;
    else           state <= state_nx;
  end

  // Next state and ready decode.
  always_comb begin
    state_nx     = state;
    in_ready_sig = 1'b0;
    unique case (state)
      COLLECT: begin
        in_ready_sig = 1'b1;
        if (in_valid_sig && cnt == T_LAST)
          state_nx = TRACEBACK;
      end
      TRACEBACK: begin
        if (cnt == '0) state_nx = OUTPUT;
      end
      OUTPUT: begin
        if (cnt == O_LAST) state_nx = COLLECT;
      end
      default: state_nx = COLLECT;
    endcase
  end

  // Counter, path metrics, traceback state, outputs.
  always_ff @(posedge clk_sig or posedge reset_sig) begin
    if (reset_sig) begin
      cnt           <= '0;
      pm[0]         <= '0;
      pm[1]         <= PM_INIT;
      pm[2]         <= PM_INIT;
      pm[3]         <= PM_INIT;
      tb_st         <= '0;
      out_valid_sig <= 1'b0;
      out_bit_sig   <= 1'b0;
      out_last_sig  <= 1'b0;
    end else begin
      out_valid_sig <= 1'b0;
      out_last_sig  <= 1'b0;
      unique case (state)
        COLLECT: begin
          if (accept) begin
            for (int i = 0; i < 4; i++)
              pm[i] <= pm_new[i];
            if (cnt == T_LAST) tb_st <= '0;
            else               cnt   <= cnt + 1'b1;
          end
        end
        TRACEBACK: begin
          tb_st <= {tb_st[0], surv[cnt][tb_st]};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        OUTPUT: begin
          out_valid_sig <= 1'b1;
          out_bit_sig   <= ubuf[cnt];
          out_last_sig  <= (cnt == O_LAST);
          if (cnt == O_LAST) begin
            cnt   <= '0;
            pm[0] <= '0;
            pm[1] <= PM_INIT;
            pm[2] <= PM_INIT;
            pm[3] <= PM_INIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Survivor decisions and traced-back bits; always
  // rewritten before use, so no reset is needed.
  always_ff @(posedge clk_sig) begin
    if (accept)
      surv[cnt] <= dec;
    if (state == TRACEBACK)
      ubuf[cnt] <= tb_st[1];
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// tb_viterbi_decoder: directed and random frames checked
// against an encoder model and the original info bits.
module tb_viterbi_decoder;

  localparam int NUM = 16;

  logic       clk_sig = 1'b0;
  logic       reset_sig = 1'b1;
  logic       in_valid_sig = 1'b0;
  logic [1:0] in_sym_sig = 2'b00;
  logic       in_ready_sig;
  logic       out_valid_sig;
  logic       out_bit_sig;
  logic       out_last_sig;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] frame [NUM];
  logic       info [NUM];

  viterbi_decoder #(.NUM(NUM)) dut (
    .clk_sig       (clk_sig),
    .reset_sig     (reset_sig),
    .in_valid_sig  (in_valid_sig),
    .in_ready_sig  (in_ready_sig),
    .in_sym_sig    (in_sym_sig),
    .out_valid_sig (out_valid_sig),
    .out_bit_sig   (out_bit_sig),
    .out_last_sig  (out_last_sig)
  );

  always #5 clk_sig = ~clk_sig;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Reference encoder: s1=u[n-1], s0=u[n-2].
  task automatic encode();
    int s1;
    int s0;
    int u;
    s1 = 0;
    s0 = 0;
    for (int t = 0; t < NUM; t++) begin
      u = int'(info[t]);
      frame[t][1] = 1'((u + s1 + s0) % 2);
      frame[t][0] = 1'((u + s0) % 2);
      s0 = s1;
      s1 = u;
    end
  endtask

  // Info 1,0,1,1,0... with its literal coded stream.
  task automatic load_s3();
    logic [1:0] lit [6];
    lit = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    for (int t = 0; t < NUM; t++) begin
      info[t]  = 1'b0;
      frame[t] = (t < 6) ? lit[t] : 2'b00;
    end
    info[0] = 1'b1;
    info[2] = 1'b1;
    info[3] = 1'b1;
  endtask

  task automatic random_frame();
    int nerr;
    int pos;
    for (int t = 0; t < NUM; t++)
      info[t] = (t < NUM - 2) ? 1'($urandom) : 1'b0;
    encode();
    nerr = $urandom_range(0, 2);
    for (int e = 0; e < nerr; e++) begin
      pos = $urandom_range(0, NUM - 1);
      frame[pos] ^= ($urandom_range(0, 1) == 1) ?
                    2'b10 : 2'b01;
    end
  endtask

  // Send frame[] then check timing and decoded bits
  // cycle by cycle from the last handshake.
  task automatic run_frame(
    input string tag,
    input int    max_gap,
    input bit    junk
  );
    int i;
    int gap;
    int budget;
    bit win;
    i = 0;
    gap = 0;
    budget = 0;
    while (i < NUM && budget < 500) begin
      @(negedge clk_sig);
      budget++;
      check($sformatf("%s_quiet", tag), out_valid_sig, 0);
      if (gap > 0) begin
        in_valid_sig = 1'b0;
        in_sym_sig   = 2'($urandom);
        gap--;
      end else begin
        in_valid_sig = 1'b1;
        in_sym_sig   = frame[i];
        if (in_ready_sig) begin
          i++;
          gap = (max_gap > 0) ?
                $urandom_range(max_gap, 1) : 0;
        end
      end
    end
    check($sformatf("%s_accepted", tag), i, NUM);
    for (int k = 0; k < 2 * NUM; k++) begin
      @(negedge clk_sig);
      in_valid_sig = junk && (k < 2 * NUM - 2);
      in_sym_sig   = 2'($urandom);
      win = (k >= NUM + 1) && (k <= 2 * NUM - 2);
      check($sformatf("%s_ready_k%0d", tag, k),
            in_ready_sig, k >= 2 * NUM - 2);
      check($sformatf("%s_valid_k%0d", tag, k),
            out_valid_sig, win);
      check($sformatf("%s_last_k%0d", tag, k),
            out_last_sig, k == 2 * NUM - 2);
      if (win)
        check($sformatf("%s_bit%0d", tag, k - NUM - 1),
              out_bit_sig, info[k - NUM - 1]);
    end
    in_valid_sig = 1'b0;
  endtask

  initial begin
    // Reset held for three cycles.
    repeat (3) begin
      @(negedge clk_sig);
      check("rst_valid", out_valid_sig, 0);
      check("rst_last", out_last_sig, 0);
    end
    reset_sig = 1'b0;
    #1;
    check("ready_after_rst", in_ready_sig, 1);

    // All-zero frame.
    for (int t = 0; t < NUM; t++) info[t] = 1'b0;
    encode();
    run_frame("zeros", 0, 1'b0);

    // Known stream 1,0,1,1.
    load_s3();
    run_frame("s3", 0, 1'b0);

    // Same stream with one symbol corrupted.
    load_s3();
    frame[1] = 2'b11;
    run_frame("s4", 0, 1'b0);

    // Gapped input, junk offered while busy.
    load_s3();
    run_frame("s5", 3, 1'b1);

    // Asynchronous reset after seven symbols.
    load_s3();
    for (int t = 0; t < 7; t++) begin
      @(negedge clk_sig);
      in_valid_sig = 1'b1;
      in_sym_sig   = frame[t];
    end
    @(posedge clk_sig);
    #2;
    reset_sig    = 1'b1;
    in_valid_sig = 1'b0;
    #1;
    check("s6_rst_valid", out_valid_sig, 0);
    check("s6_rst_last", out_last_sig, 0);
    check("s6_rst_ready", in_ready_sig, 1);
    @(negedge clk_sig);
    reset_sig = 1'b0;
    run_frame("s6", 0, 1'b0);

    // Asynchronous reset while bits are streaming out.
    random_frame();
    for (int t = 0; t < NUM; t++) begin
      @(negedge clk_sig);
      in_valid_sig = 1'b1;
      in_sym_sig   = frame[t];
    end
    @(negedge clk_sig);
    in_valid_sig = 1'b0;
    begin
      int wait_cyc;
      wait_cyc = 0;
      while (!out_valid_sig && wait_cyc < 100) begin
        @(negedge clk_sig);
        wait_cyc++;
      end
      check("s7_out_seen", out_valid_sig, 1);
    end
    @(posedge clk_sig);
    #2;
    reset_sig = 1'b1;
    #1;
    check("s7_rst_valid", out_valid_sig, 0);
    check("s7_rst_last", out_last_sig, 0);
    check("s7_rst_ready", in_ready_sig, 1);
    @(negedge clk_sig);
    reset_sig = 1'b0;

    // Random frames with up to two bit errors.
    for (int r = 0; r < 6; r++) begin
      random_frame();
      run_frame($sformatf("rnd%0d", r), r % 4,
                (r % 2) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
